// File: rtl/peregrine_iram1_initiator_pkg.sv
// Shared types, default window constants and the lane-merge helper for the IRam1 initiator.
package peregrine_iram1_init_pkg;

  localparam logic [31:0] IRAM1_MEM_BEG = 32'h0098_0000;
  localparam logic [31:0] IRAM1_MEM_END = 32'h009f_ffff;
  localparam int          IRAM1_AWIDTH  = 17;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_RD_CAP  = 3'd2,
    ST_RMW_RD  = 3'd3,
    ST_RMW_CAP = 3'd4,
    ST_WR      = 3'd5,
    ST_RSP     = 3'd6
  } state_e;

  // Per-lane select: enabled lanes take the new data, the rest keep the array word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        merged[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/peregrine_iram1_initiator_if.sv
// Request/response bus plus IRam1 array port; slave = initiator view, master = system/memory view.
interface peregrine_iram1_initiator_if #(
  parameter int AWIDTH = peregrine_iram1_init_pkg::IRAM1_AWIDTH
);
  logic              ReqValid;
  logic              ReqReady;
  logic [31:0]       ReqAddr;
  logic              ReqWrite;
  logic [31:0]       ReqWrData;
  logic [3:0]        ReqByteEn;
  logic              RspValid;
  logic              RspReady;
  logic [31:0]       RspData;
  logic              RspErr;
  logic [AWIDTH-1:0] IRam1Addr;
  logic              IRam1En;
  logic              IRam1Wr;
  logic [31:0]       IRam1WrData;
  logic              IRam1LoadStore;
  logic [31:0]       IRam1Data;

  modport slave (
    input  ReqValid, ReqAddr, ReqWrite, ReqWrData, ReqByteEn, RspReady, IRam1Data,
    output ReqReady, RspValid, RspData, RspErr,
           IRam1Addr, IRam1En, IRam1Wr, IRam1WrData, IRam1LoadStore
  );

  modport master (
    output ReqValid, ReqAddr, ReqWrite, ReqWrData, ReqByteEn, RspReady, IRam1Data,
    input  ReqReady, RspValid, RspData, RspErr,
           IRam1Addr, IRam1En, IRam1Wr, IRam1WrData, IRam1LoadStore
  );
endinterface

// File: rtl/peregrine_iram1_initiator.sv
// IRam1 initiator: one outstanding word request, range check, read-modify-write for partial writes.
// Optional saturating completion counters when PEREGRINE_IRAM1_INIT_STATS_EN is defined.
module peregrine_iram1_initiator
  import peregrine_iram1_init_pkg::*;
#(
  parameter logic [31:0] MEM_BEG = IRAM1_MEM_BEG,
  parameter logic [31:0] MEM_END = IRAM1_MEM_END,
  parameter int          AWIDTH  = IRAM1_AWIDTH
) (
  input  logic                         CLK,
  input  logic                         Reset,
  peregrine_iram1_initiator_if.slave   bus
`ifdef PEREGRINE_IRAM1_INIT_STATS_EN
  ,
  output logic [15:0]                  StatRd,
  output logic [15:0]                  StatWr,
  output logic [15:0]                  StatErr
`endif
);

  localparam logic [2:0] S_IDLE    = ST_IDLE;
  localparam logic [2:0] S_RD      = ST_RD;
  localparam logic [2:0] S_RD_CAP  = ST_RD_CAP;
  localparam logic [2:0] S_RMW_RD  = ST_RMW_RD;
  localparam logic [2:0] S_RMW_CAP = ST_RMW_CAP;
  localparam logic [2:0] S_WR      = ST_WR;
  localparam logic [2:0] S_RSP     = ST_RSP;

  logic [2:0]        state_r;
  logic [31:0]       wdata_r;
  logic [3:0]        be_r;
  logic [AWIDTH-1:0] iram_addr_r;
  logic              iram_en_r;
  logic              iram_wr_r;
  logic [31:0]       iram_wdata_r;
  logic              rsp_valid_r;
  logic [31:0]       rsp_data_r;
  logic              rsp_err_r;
  logic              addr_err_s;
  logic [AWIDTH-1:0] word_idx_s;

  assign addr_err_s = (bus.ReqAddr[1:0] != 2'b00) || (bus.ReqAddr < MEM_BEG) ||
                      (bus.ReqAddr > MEM_END);
  assign word_idx_s = AWIDTH'((bus.ReqAddr - MEM_BEG) >> 5'd2);

  // Ready only in IDLE and forced low while reset is asserted.
  assign bus.ReqReady       = (state_r == S_IDLE) && !Reset;
  assign bus.RspValid       = rsp_valid_r;
  assign bus.RspData        = rsp_data_r;
  assign bus.RspErr         = rsp_err_r;
  assign bus.IRam1Addr      = iram_addr_r;
  assign bus.IRam1En        = iram_en_r;
  assign bus.IRam1Wr        = iram_wr_r;
  assign bus.IRam1WrData    = iram_wdata_r;
  assign bus.IRam1LoadStore = iram_en_r;

  // Transaction FSM; array strobes are set on the same edge that enters RD/RMW_RD/WR.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_r      <= S_IDLE;
      wdata_r      <= 32'd0;
      be_r         <= 4'd0;
      iram_addr_r  <= '0;
      iram_en_r    <= 1'b0;
      iram_wr_r    <= 1'b0;
      iram_wdata_r <= 32'd0;
      rsp_valid_r  <= 1'b0;
      rsp_data_r   <= 32'd0;
      rsp_err_r    <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (bus.ReqValid) begin
            wdata_r     <= bus.ReqWrData;
            be_r        <= bus.ReqByteEn;
            iram_addr_r <= word_idx_s;
            if (addr_err_s) begin
              state_r     <= S_RSP;
              rsp_valid_r <= 1'b1;
              rsp_err_r   <= 1'b1;
              rsp_data_r  <= 32'd0;
            end else if (!bus.ReqWrite) begin
              state_r   <= S_RD;
              iram_en_r <= 1'b1;
              iram_wr_r <= 1'b0;
            end else if (bus.ReqByteEn == 4'hF) begin
              state_r      <= S_WR;
              iram_en_r    <= 1'b1;
              iram_wr_r    <= 1'b1;
              iram_wdata_r <= bus.ReqWrData;
            end else if (bus.ReqByteEn == 4'h0) begin
              state_r     <= S_RSP;
              rsp_valid_r <= 1'b1;
              rsp_err_r   <= 1'b0;
              rsp_data_r  <= 32'd0;
            end else begin
              state_r   <= S_RMW_RD;
              iram_en_r <= 1'b1;
              iram_wr_r <= 1'b0;
            end
          end
        end
        S_RD: begin
          iram_en_r <= 1'b0;
          state_r   <= S_RD_CAP;
        end
        S_RD_CAP: begin
          rsp_data_r  <= bus.IRam1Data;
          rsp_err_r   <= 1'b0;
          rsp_valid_r <= 1'b1;
          state_r     <= S_RSP;
        end
        S_RMW_RD: begin
          iram_en_r <= 1'b0;
          state_r   <= S_RMW_CAP;
        end
        S_RMW_CAP: begin
          iram_en_r    <= 1'b1;
          iram_wr_r    <= 1'b1;
          iram_wdata_r <= merge_bytes(bus.IRam1Data, wdata_r, be_r);
          state_r      <= S_WR;
        end
        S_WR: begin
          iram_en_r   <= 1'b0;
          iram_wr_r   <= 1'b0;
          rsp_data_r  <= 32'd0;
          rsp_err_r   <= 1'b0;
          rsp_valid_r <= 1'b1;
          state_r     <= S_RSP;
        end
        S_RSP: begin
          if (bus.RspReady) begin
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 32'd0;
            rsp_err_r   <= 1'b0;
            state_r     <= S_IDLE;
          end
        end
        default: begin
          iram_en_r   <= 1'b0;
          iram_wr_r   <= 1'b0;
          rsp_valid_r <= 1'b0;
          state_r     <= S_IDLE;
        end
      endcase
    end
  end

`ifdef PEREGRINE_IRAM1_INIT_STATS_EN
  logic        is_write_r;
  logic        rsp_hs_s;
  logic [15:0] stat_rd_r;
  logic [15:0] stat_wr_r;
  logic [15:0] stat_err_r;

  assign rsp_hs_s = (state_r == S_RSP) && bus.RspReady;
  assign StatRd   = stat_rd_r;
  assign StatWr   = stat_wr_r;
  assign StatErr  = stat_err_r;

  // Completion counters, classified at the response handshake and saturating at all-ones.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      is_write_r <= 1'b0;
      stat_rd_r  <= 16'd0;
      stat_wr_r  <= 16'd0;
      stat_err_r <= 16'd0;
    end else begin
      if ((state_r == S_IDLE) && bus.ReqValid) begin
        is_write_r <= bus.ReqWrite;
      end
      if (rsp_hs_s) begin
        if (rsp_err_r) begin
          if (stat_err_r != 16'hFFFF) stat_err_r <= stat_err_r + 16'd1;
        end else if (is_write_r) begin
          if (stat_wr_r != 16'hFFFF) stat_wr_r <= stat_wr_r + 16'd1;
        end else begin
          if (stat_rd_r != 16'hFFFF) stat_rd_r <= stat_rd_r + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_peregrine_iram1_initiator.sv
// Directed self-checking bench for peregrine_iram1_initiator with a synchronous IRam1 array model.
module tb_peregrine_iram1_initiator;

  logic CLK;
  logic Reset;

  peregrine_iram1_initiator_if #(.AWIDTH(17)) bus ();

`ifdef PEREGRINE_IRAM1_INIT_STATS_EN
  logic [15:0] stat_rd;
  logic [15:0] stat_wr;
  logic [15:0] stat_err;
`endif

  peregrine_iram1_initiator dut (
    .CLK     (CLK),
    .Reset   (Reset),
    .bus     (bus)
`ifdef PEREGRINE_IRAM1_INIT_STATS_EN
    ,
    .StatRd  (stat_rd),
    .StatWr  (stat_wr),
    .StatErr (stat_err)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [31:0] mem [0:131071];
  int          en_cnt;
  int          wr_cnt;
  int          inv_bad;
  logic [16:0] last_addr;
  logic [31:0] last_wdata;
  int          n_checks;
  int          n_err;

  // Array model: read data appears the cycle after the enable cycle; strobe bookkeeping.
  always @(posedge CLK) begin
    if (bus.IRam1En) begin
      en_cnt    <= en_cnt + 1;
      last_addr <= bus.IRam1Addr;
      if (bus.IRam1Wr) begin
        wr_cnt              <= wr_cnt + 1;
        last_wdata          <= bus.IRam1WrData;
        mem[bus.IRam1Addr]  <= bus.IRam1WrData;
      end else begin
        bus.IRam1Data <= mem[bus.IRam1Addr];
      end
    end
    if ((bus.IRam1Wr && !bus.IRam1En) || (bus.IRam1LoadStore != bus.IRam1En)) begin
      inv_bad <= inv_bad + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] addr, input logic wr, input logic [31:0] data,
                       input logic [3:0] be);
    en_cnt = 0;
    wr_cnt = 0;
    check_val("req_ready", {31'd0, bus.ReqReady}, 32'd1);
    bus.ReqValid  = 1'b1;
    bus.ReqAddr   = addr;
    bus.ReqWrite  = wr;
    bus.ReqWrData = data;
    bus.ReqByteEn = be;
    @(posedge CLK);
    #1;
    bus.ReqValid  = 1'b0;
  endtask

  task automatic do_req(input logic [31:0] addr, input logic wr, input logic [31:0] data,
                        input logic [3:0] be, output int lat, output logic [31:0] rdata,
                        output logic rerr);
    bit seen;
    issue(addr, wr, data, be);
    lat  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge CLK);
      if (bus.RspValid) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    rdata = bus.RspData;
    rerr  = bus.RspErr;
    if (bus.RspReady) @(negedge CLK);
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        er;
    bit          stable;

    n_checks = 0;
    n_err    = 0;
    en_cnt   = 0;
    wr_cnt   = 0;
    inv_bad  = 0;
    mem[0]   = 32'hDEADBEEF;
    mem[4]   = 32'hAABBCCDD;
    mem[5]   = 32'h01020304;
    bus.IRam1Data = 32'd0;
    Reset         = 1'b1;
    bus.ReqValid  = 1'b0;
    bus.ReqAddr   = 32'd0;
    bus.ReqWrite  = 1'b0;
    bus.ReqWrData = 32'd0;
    bus.ReqByteEn = 4'd0;
    bus.RspReady  = 1'b1;

    repeat (3) @(negedge CLK);
    check_val("rst_ready", {31'd0, bus.ReqReady}, 32'd0);
    check_val("rst_rspvalid", {31'd0, bus.RspValid}, 32'd0);
    check_val("rst_en", {31'd0, bus.IRam1En}, 32'd0);
    check_val("rst_addr", {15'd0, bus.IRam1Addr}, 32'd0);
    check_val("rst_rspdata", bus.RspData, 32'd0);
    check_val("rst_rsperr", {31'd0, bus.RspErr}, 32'd0);
    Reset = 1'b0;
    #1;
    check_val("ready_after_rst", {31'd0, bus.ReqReady}, 32'd1);

    // Read of index 0
    do_req(32'h0098_0000, 1'b0, 32'd0, 4'h0, lat, rd, er);
    check_val("rd0_lat", lat, 32'd3);
    check_val("rd0_data", rd, 32'hDEADBEEF);
    check_val("rd0_err", {31'd0, er}, 32'd0);
    check_val("rd0_en_cycles", en_cnt, 32'd1);
    check_val("rd0_wr_cycles", wr_cnt, 32'd0);
    check_val("rd0_addr", {15'd0, last_addr}, 32'd0);

    // Full write to the last word, then read back
    do_req(32'h009F_FFFC, 1'b1, 32'h12345678, 4'hF, lat, rd, er);
    check_val("wf_lat", lat, 32'd2);
    check_val("wf_data", rd, 32'd0);
    check_val("wf_err", {31'd0, er}, 32'd0);
    check_val("wf_en_cycles", en_cnt, 32'd1);
    check_val("wf_wr_cycles", wr_cnt, 32'd1);
    check_val("wf_addr", {15'd0, last_addr}, 32'h0001FFFF);
    check_val("wf_wdata", last_wdata, 32'h12345678);
    do_req(32'h009F_FFFC, 1'b0, 32'd0, 4'h0, lat, rd, er);
    check_val("wf_readback", rd, 32'h12345678);

    // Read-modify-write on index 4
    do_req(32'h0098_0010, 1'b1, 32'h11223344, 4'b0101, lat, rd, er);
    check_val("rmw_lat", lat, 32'd4);
    check_val("rmw_err", {31'd0, er}, 32'd0);
    check_val("rmw_en_cycles", en_cnt, 32'd2);
    check_val("rmw_wr_cycles", wr_cnt, 32'd1);
    check_val("rmw_wdata", last_wdata, 32'hAA22CC44);
    check_val("rmw_mem", mem[4], 32'hAA22CC44);

    // Error cases and the empty write
    do_req(32'h0098_0002, 1'b0, 32'd0, 4'h0, lat, rd, er);
    check_val("mis_lat", lat, 32'd1);
    check_val("mis_err", {31'd0, er}, 32'd1);
    check_val("mis_data", rd, 32'd0);
    check_val("mis_en_cycles", en_cnt, 32'd0);
    do_req(32'h00A0_0000, 1'b1, 32'hFFFFFFFF, 4'hF, lat, rd, er);
    check_val("hi_err", {31'd0, er}, 32'd1);
    check_val("hi_en_cycles", en_cnt, 32'd0);
    do_req(32'h0097_FFFC, 1'b0, 32'd0, 4'h0, lat, rd, er);
    check_val("lo_err", {31'd0, er}, 32'd1);
    do_req(32'h0098_0000, 1'b1, 32'h55555555, 4'h0, lat, rd, er);
    check_val("be0_lat", lat, 32'd1);
    check_val("be0_err", {31'd0, er}, 32'd0);
    check_val("be0_en_cycles", en_cnt, 32'd0);

    // Response backpressure
    bus.RspReady = 1'b0;
    do_req(32'h0098_0000, 1'b0, 32'd0, 4'h0, lat, rd, er);
    check_val("bp_lat", lat, 32'd3);
    check_val("bp_data", rd, 32'hDEADBEEF);
    stable = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      if (!bus.RspValid || bus.RspData != 32'hDEADBEEF || bus.ReqReady) stable = 1'b0;
    end
    check_val("bp_stable", {31'd0, stable}, 32'd1);
    bus.RspReady = 1'b1;
    @(negedge CLK);
    do_req(32'h009F_FFFC, 1'b0, 32'd0, 4'h0, lat, rd, er);
    check_val("bp_next_lat", lat, 32'd3);
    check_val("bp_next_data", rd, 32'h12345678);

    // Reset in the RMW capture cycle
    issue(32'h0098_0014, 1'b1, 32'hA0B0C0D0, 4'b0011);
    @(negedge CLK);
    @(negedge CLK);
    Reset = 1'b1;
    #1;
    check_val("mid_rst_en", {31'd0, bus.IRam1En}, 32'd0);
    check_val("mid_rst_wr", {31'd0, bus.IRam1Wr}, 32'd0);
    check_val("mid_rst_rspvalid", {31'd0, bus.RspValid}, 32'd0);
    check_val("mid_rst_ready", {31'd0, bus.ReqReady}, 32'd0);
    check_val("mid_rst_wdata", bus.IRam1WrData, 32'd0);
    repeat (3) @(negedge CLK);
    check_val("mid_rst_no_write", wr_cnt, 32'd0);
    check_val("mid_rst_mem", mem[5], 32'h01020304);
    Reset = 1'b0;
    #1;
    check_val("mid_rst_ready_after", {31'd0, bus.ReqReady}, 32'd1);
    do_req(32'h0098_0014, 1'b0, 32'd0, 4'h0, lat, rd, er);
    check_val("mid_rst_readback", rd, 32'h01020304);

`ifdef PEREGRINE_IRAM1_INIT_STATS_EN
    check_val("stat_rd", {16'd0, stat_rd}, 32'd1);
    check_val("stat_wr", {16'd0, stat_wr}, 32'd0);
    check_val("stat_err", {16'd0, stat_err}, 32'd0);
`endif

    check_val("iram_strobes", inv_bad, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
